// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: width calculation for the occupancy count.
package elastic_pipe_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 1; i < n; i = i << 1) r++;
    return r;
  endfunction

  // Occupancy counter width; never narrower than one bit so the port always exists.
  function automatic int count_width(input int stages);
    return (clog2(stages + 1) < 1) ? 1 : clog2(stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register slot of the elastic pipe: valid bit with async clear plus a payload
// register that only captures real beats.
module elastic_pipe_stage #(
  parameter int DATA_WIDTH = 16,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_en;

  always_comb begin
    // NOTE: assign a default first so every path drives valid_d and no latch is inferred.
    valid_d = valid_q;
    if (flush_i)     valid_d = 1'b0;
    else if (load_i) valid_d = valid_i;
  end

  // Payload only moves with a real beat, so bubbles never toggle the data bus.
  assign data_en = load_i & valid_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  if (CLEAR_DATA) begin : g_clear_data
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      data_q <= '0;
      else if (flush_i) data_q <= '0;
      else if (data_en) data_q <= data_i;
    end
  end else begin : g_keep_data
    // NOTE: payload is deliberately left unreset; valid_q alone says whether it means anything.
    always_ff @(posedge clk_i) begin
      if (data_en) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// NUM_STAGES-deep bubble-collapsing valid/ready pipeline with flush and occupancy count;
// NUM_STAGES = 0 degenerates to a combinational pass-through.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter  int NUM_STAGES = 2,
  parameter  int DATA_WIDTH = 16,
  parameter  bit CLEAR_DATA = 1'b0,
  localparam int CW         = count_width(NUM_STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [CW-1:0]         count_o
);

  if (NUM_STAGES == 0) begin : g_bypass
    assign m_valid_o = s_valid_i & ~flush_i;
    assign s_ready_o = m_ready_i & ~flush_i;
    assign m_data_o  = s_data_i;
    assign count_o   = '0;
  end else begin : g_pipe
    logic [NUM_STAGES:0]   rdy;
    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] v_in;
    logic [DATA_WIDTH-1:0] d    [NUM_STAGES];
    logic [DATA_WIDTH-1:0] d_in [NUM_STAGES];
    logic [CW-1:0]         cnt;

    // A stage may load when it is empty or its successor is moving on this cycle.
    assign rdy[NUM_STAGES] = m_ready_i & ~flush_i;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign v_in[i] = s_valid_i;
        assign d_in[i] = s_data_i;
      end else begin : g_body
        assign v_in[i] = v[i-1];
        assign d_in[i] = d[i-1];
      end

      assign rdy[i] = ~v[i] | rdy[i+1];

      elastic_pipe_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_stage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (rdy[i]),
        .valid_i (v_in[i]),
        .data_i  (d_in[i]),
        .valid_o (v[i]),
        .data_o  (d[i])
      );
    end

    always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_STAGES; i++) cnt = cnt + CW'(v[i]);
    end

    assign s_ready_o = rdy[0] & ~flush_i;
    assign m_valid_o = v[NUM_STAGES-1] & ~flush_i;
    assign m_data_o  = d[NUM_STAGES-1];
    assign count_o   = cnt;
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench: accepted beats are queued, a negedge monitor pops and compares
// every delivered beat, plus directed checks for latency, stall, bubbles, reset and flush.
module tb_elastic_pipe;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;

  logic          s_ready, m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    count;

  logic          p_s_ready, p_m_valid;
  logic [DW-1:0] p_m_data;
  logic [0:0]    p_count;

  logic          c_s_ready, c_m_valid;
  logic [DW-1:0] c_m_data;
  logic [1:0]    c_count;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_in     = 0;
  int            n_out    = 0;
  logic [DW-1:0] exp_q [$];
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data_q = '0;

  always #5 clk = ~clk;

  elastic_pipe #(.NUM_STAGES(3), .DATA_WIDTH(DW), .CLEAR_DATA(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .count_o(count)
  );

  elastic_pipe #(.NUM_STAGES(0), .DATA_WIDTH(DW), .CLEAR_DATA(1'b0)) u_pass (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(p_s_ready), .s_data_i(s_data),
    .m_valid_o(p_m_valid), .m_ready_i(m_ready), .m_data_o(p_m_data), .count_o(p_count)
  );

  elastic_pipe #(.NUM_STAGES(2), .DATA_WIDTH(DW), .CLEAR_DATA(1'b1)) u_clr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(c_s_ready), .s_data_i(s_data),
    .m_valid_o(c_m_valid), .m_ready_i(m_ready), .m_data_o(c_m_data), .count_o(c_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: occupancy, hold rule, pass-through build, then pop/push for this edge.
  always @(negedge clk) begin
    check("pass_m_valid", {31'd0, p_m_valid}, {31'd0, s_valid & ~flush});
    check("pass_s_ready", {31'd0, p_s_ready}, {31'd0, m_ready & ~flush});
    check("pass_m_data", {16'd0, p_m_data}, {16'd0, s_data});
    check("pass_count", {31'd0, p_count}, 32'd0);
    if (!rst_n) begin
      exp_q.delete();
      hold_q = 1'b0;
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_count", {30'd0, count}, 32'd0);
    end else begin
      check("count", {30'd0, count}, exp_q.size());
      if (flush) begin
        check("flush_m_valid", {31'd0, m_valid}, 32'd0);
        check("flush_s_ready", {31'd0, s_ready}, 32'd0);
        exp_q.delete();
        hold_q = 1'b0;
      end else begin
        if (hold_q) begin
          check("hold_valid", {31'd0, m_valid}, 32'd1);
          check("hold_data", {16'd0, m_data}, {16'd0, hold_data_q});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", {16'd0, m_data}, 32'hffff_ffff);
          else check("beat_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
          n_out++;
        end
        if (s_valid && s_ready) begin
          exp_q.push_back(s_data);
          n_in++;
        end
        hold_q      = m_valid & ~m_ready;
        hold_data_q = m_data;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    logic acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int gaps;

    #1;
    check("init_m_valid", {31'd0, m_valid}, 32'd0);
    check("init_count", {30'd0, count}, 32'd0);
    check("init_clr_data", {16'd0, c_m_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Streaming 1..100 with no stall: three-edge latency, then one beat per cycle.
    fork
      begin
        for (int i = 1; i <= 100; i++) send(16'(i));
        s_valid = 1'b0;
      end
      begin
        k = 0;
        do begin
          @(posedge clk);
          k++;
          @(negedge clk);
        end while (!m_valid && k < 10);
        check("latency", k, 32'd3);
        check("first_data", {16'd0, m_data}, 32'd1);
        gaps = 0;
        repeat (99) begin
          @(negedge clk);
          if (!m_valid) gaps++;
        end
        check("no_gaps", gaps, 32'd0);
      end
    join
    wait_drain();
    check("stream_out", n_out, 32'd100);

    // Backpressure: 10 stalled cycles mid-stream.
    fork
      begin
        for (int i = 101; i <= 130; i++) send(16'(i));
        s_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_count", {30'd0, count}, 32'd3);
        check("stall_s_ready", {31'd0, s_ready}, 32'd0);
        check("stall_m_valid", {31'd0, m_valid}, 32'd1);
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_out", n_out, 32'd130);

    // Bubbles: alternating valid into a stalled pipe compacts to full.
    @(posedge clk);
    #1 m_ready = 1'b0;
    send(16'd200);
    s_valid = 1'b0; @(posedge clk); #1;
    send(16'd201);
    s_valid = 1'b0; @(posedge clk); #1;
    send(16'd202);
    s_valid = 1'b0;
    @(negedge clk);
    check("bubble_count", {30'd0, count}, 32'd3);
    check("bubble_s_ready", {31'd0, s_ready}, 32'd0);
    check("bubble_head", {16'd0, m_data}, 32'd200);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_drain();
    check("bubble_out", n_out, 32'd133);

    // Asynchronous reset in the middle of a cycle with a full pipe.
    @(posedge clk);
    #1 m_ready = 1'b0;
    send(16'd300);
    send(16'd301);
    send(16'd302);
    s_valid = 1'b0;
    @(negedge clk);
    check("prefill_count", {30'd0, count}, 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("async_rst_count", {30'd0, count}, 32'd0);
    check("async_rst_clr_data", {16'd0, c_m_data}, 32'd0);
    check("async_rst_clr_count", {30'd0, c_count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_release_clr_ready", {31'd0, c_s_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Flush dominates simultaneous S and M handshakes.
    send(16'd400);
    send(16'd401);
    s_valid = 1'b0;
    @(negedge clk);
    check("preflush_count", {30'd0, count}, 32'd2);
    @(posedge clk);
    #1;
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0bad;
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_cycle_s_ready", {31'd0, s_ready}, 32'd0);
    check("flush_cycle_m_valid", {31'd0, m_valid}, 32'd0);
    check("flush_cycle_clr_valid", {31'd0, c_m_valid}, 32'd0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("postflush_count", {30'd0, count}, 32'd0);
    check("postflush_m_valid", {31'd0, m_valid}, 32'd0);
    check("postflush_clr_data", {16'd0, c_m_data}, 32'd0);
    check("postflush_clr_count", {30'd0, c_count}, 32'd0);
    check("total_out", n_out, 32'd133);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
